uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 SHALL have parameter DATA_W, default 9, frame payload width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32768, max clocks waiting for tx_done (one 11-bit frame at 9600 baud on 25 MHz is about 28646 clocks).
REQ-004 Ports: clock  in  1  single clock, all state on posedge.
REQ-005 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: req  in  NUM_REQ  per-requester frame request, level, held until ack.
REQ-007 Ports: req_data  in  NUM_REQ*DATA_W  requester i payload at bits [i*DATA_W +: DATA_W].
REQ-008 Ports: ack  out  NUM_REQ  one-hot, 1-cycle pulse: payload of requester i latched.
REQ-009 Ports: cmpl  out  NUM_REQ  one-hot, 1-cycle pulse: requester i frame fully sent.
REQ-010 Ports: tx_data  out  DATA_W  payload presented to transmitter, stable from ack until return to IDLE.
REQ-011 Ports: tx_send  out  1  1-cycle start pulse to transmitter.
REQ-012 Ports: tx_ready  in  1  transmitter idle and able to accept tx_send.
REQ-013 Ports: tx_done  in  1  1-cycle pulse, transmitter finished stop bit.
REQ-014 Ports: busy  out  1  high whenever state is not IDLE.
REQ-015 Ports: timeout_err  out  1  1-cycle pulse, frame abandoned after TIMEOUT_CYCLES.

Function
REQ-016 FSM states IDLE, SEND, WAIT_DONE; state register updated on posedge clock only.
REQ-017 IDLE: if req != 0 and tx_ready = 1, at the next edge: state->SEND, grant index g latched, tx_data <= req_data[g], ack[g] = 1 for that one cycle; otherwise remain IDLE.
REQ-018 Selection: round-robin; scan starts at pointer ptr, ascending, wrapping NUM_REQ-1 -> 0; first asserted req wins.
REQ-019 ptr SHALL become (g+1) mod NUM_REQ when the frame for g completes or times out; ptr unchanged otherwise.
REQ-020 SEND: tx_send = 1 for exactly this one cycle; next edge state->WAIT_DONE; timeout counter cleared.
REQ-021 WAIT_DONE: counter increments each cycle; on tx_done = 1 -> IDLE next edge, cmpl[g] = 1 for one cycle.
REQ-022 WAIT_DONE: counter reaching TIMEOUT_CYCLES-1 with tx_done = 0 -> IDLE next edge, timeout_err = 1 for one cycle, no cmpl.
REQ-023 tx_done and timeout terminal count in same cycle: tx_done wins (cmpl, no timeout_err).
REQ-024 tx_done seen in IDLE or SEND SHALL be ignored.
REQ-025 Latency: req sampled in cycle N -> ack in N+1 -> tx_send in N+2 (SEND cycle).
REQ-026 Back-to-back: after cmpl cycle the FSM is IDLE and can grant in that same cycle, so next ack occurs at the earliest 1 cycle after cmpl.
REQ-027 req dropped before ack: not served, no ack/cmpl; req changes after ack do not affect tx_data.
REQ-028 At most one bit of ack, cmpl is set in any cycle; ack and cmpl are never high in the same cycle.
REQ-029 Counter width $clog2(TIMEOUT_CYCLES)+1 bits, no wrap before terminal count.

Reset
REQ-030 reset_n low SHALL immediately force: state IDLE, ptr 0, tx_data 0, tx_send 0, ack 0, cmpl 0, busy 0, timeout_err 0, counter 0.
REQ-031 Reset mid-frame abandons the frame: no cmpl, no timeout_err; first grant after release uses ptr 0.

Verification
REQ-032 Single request: req=4'b0100, req_data[2]=9'h1A5, tx_ready=1 -> ack=4'b0100 at N+1, tx_send and tx_data=9'h1A5 at N+2; tx_done 50 cycles later -> cmpl=4'b0100 next cycle, busy low.
REQ-033 Fairness: req=4'b1111 held, transmitter model returns tx_done 10 cycles after tx_send -> ack order 0,1,2,3,0 and each cmpl matches preceding ack.
REQ-034 Timeout: TIMEOUT_CYCLES=16, tx_done never asserted -> timeout_err exactly 16 cycles after SEND, ptr advances, pending req=4'b0010 then granted.
REQ-035 tx_done and terminal count in same cycle -> cmpl asserted, timeout_err stays 0.
REQ-036 tx_ready=0 with req=4'b0001 for 20 cycles -> no ack, busy=0; tx_ready rises -> ack next cycle.
REQ-037 reset_n pulsed low during WAIT_DONE -> all outputs 0 same cycle, no cmpl; after release req=4'b1000 granted normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters. A round-robin pointer
// picks the next requester, its payload is latched and handed to the
// transmitter, and the frame is tracked until tx_done or a timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 9,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        cmpl,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_send,
  input  logic                      tx_ready,
  input  logic                      tx_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [CNT_W-1:0]   CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT  = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [PTR_W-1:0]   grant_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [PTR_W-1:0]   ptr_next;

  logic [DATA_W-1:0]  req_word [NUM_REQ];

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  // Unpack the flat payload bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: scan from ptr upward with wrap. The loop runs from the
  // farthest offset down to offset 0 so the last hit is the first in scan order.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_reg;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Pointer value once the current grant finishes (completes or times out).
  assign ptr_next = (grant_reg == LAST_IDX) ? '0 : grant_reg + PTR_W'(1);

  // Arbiter FSM with all outputs registered; pulse outputs default low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      cnt_reg     <= '0;
      tx_data     <= '0;
      tx_send     <= 1'b0;
      ack         <= '0;
      cmpl        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ack         <= '0;
      cmpl        <= '0;
      tx_send     <= 1'b0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid && tx_ready) begin
            state_reg <= SEND;
            grant_reg <= pick_idx;
            tx_data   <= req_word[pick_idx];
            ack       <= ONE_HOT << pick_idx;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          // The start pulse becomes visible the cycle after ack.
          state_reg <= WAIT_DONE;
          cnt_reg   <= '0;
          tx_send   <= 1'b1;
        end
        WAIT_DONE: begin
          // tx_done takes priority over a timeout landing in the same cycle.
          if (tx_done) begin
            state_reg <= IDLE;
            cmpl      <= ONE_HOT << grant_reg;
            ptr_reg   <= ptr_next;
            busy      <= 1'b0;
          end else if (cnt_reg == CNT_TERM) begin
            state_reg   <= IDLE;
            timeout_err <= 1'b1;
            ptr_reg     <= ptr_next;
            busy        <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple
// transmitter model whose per-frame tx_done delay comes from a queue.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 9;
  localparam int TO   = 64;

  localparam int K_ACK  = 0;
  localparam int K_CMPL = 1;
  localparam int K_TO   = 2;

  typedef struct {
    int            kind;
    int            idx;
    logic [DW-1:0] data;
    bit            b2b;
  } exp_t;

  logic               clock;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    cmpl;
  logic [DW-1:0]      tx_data;
  logic               tx_send;
  logic               tx_ready;
  logic               tx_done;
  logic               busy;
  logic               timeout_err;

  exp_t exp_q[$];
  int   delay_q[$];
  int   want_cnt [NREQ];
  int   ack_cnt  [NREQ];
  int   cyc = 0;
  int   ack_cyc = 0;
  int   send_cyc = 0;
  int   cmpl_cyc = -100;
  int   cur_delay = -1;
  int   done_at = -1;
  logic [DW-1:0] cur_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ),
    .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .cmpl(cmpl),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_ready(tx_ready),
    .tx_done(tx_done),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // A requester holds req while it still wants more frames than it has been acked.
  always_comb begin
    req = '0;
    for (int i = 0; i < NREQ; i++) req[i] = (want_cnt[i] > ack_cnt[i]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input int kind, input int idx, input logic [DW-1:0] data, input bit b2b);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.data = data;
    e.b2b  = b2b;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int idx, input logic [DW-1:0] data, input bit b2b);
    push_exp(K_ACK, idx, data, b2b);
    push_exp(K_CMPL, idx, data, 1'b0);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  // Transmitter model: pulse tx_done in the scheduled cycle, regardless of DUT state.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      tx_done = (done_at >= 0) && (cyc == done_at);
    end
  end

  // Monitor: pops the scoreboard on every ack / cmpl / timeout and checks timing.
  always @(negedge clock) begin
    exp_t e;
    int   d;
    if (reset_n) begin
      if (ack != '0) begin
        check("ack_cmpl_excl", 32'(ack & cmpl), 0);
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 32'(ack), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_kind", e.kind, K_ACK);
          check("ack_onehot", 32'(ack), 32'(1) << e.idx);
          check("ack_data", 32'(tx_data), 32'(e.data));
          if (e.b2b) check("b2b_gap", cyc - cmpl_cyc, 1);
          cur_data = e.data;
        end
        for (int i = 0; i < NREQ; i++) if (ack[i]) ack_cnt[i]++;
        ack_cyc = cyc;
        $display("cycle %0d: ack=%b tx_data=%h", cyc, ack, tx_data);
      end
      if (tx_send) begin
        check("send_lat", cyc - ack_cyc, 1);
        check("send_data", 32'(tx_data), 32'(cur_data));
        d = (delay_q.size() > 0) ? delay_q.pop_front() : -1;
        cur_delay = d;
        done_at   = (d < 0) ? -1 : cyc + d;
        send_cyc  = cyc;
        $display("cycle %0d: tx_send tx_data=%h", cyc, tx_data);
      end
      if (cmpl != '0) begin
        if (exp_q.size() == 0) begin
          check("cmpl_unexpected", 32'(cmpl), 0);
        end else begin
          e = exp_q.pop_front();
          check("cmpl_kind", e.kind, K_CMPL);
          check("cmpl_onehot", 32'(cmpl), 32'(1) << e.idx);
          check("cmpl_lat", cyc - send_cyc, cur_delay + 1);
          check("cmpl_busy", 32'(busy), 0);
          check("cmpl_no_to", 32'(timeout_err), 0);
        end
        cmpl_cyc = cyc;
        $display("cycle %0d: cmpl=%b", cyc, cmpl);
      end
      if (timeout_err) begin
        if (exp_q.size() == 0) begin
          check("to_unexpected", 32'(timeout_err), 0);
        end else begin
          e = exp_q.pop_front();
          check("to_kind", e.kind, K_TO);
          check("to_lat", cyc - send_cyc, TO);
          check("to_busy", 32'(busy), 0);
        end
        $display("cycle %0d: timeout_err", cyc);
      end
    end
  end

  initial begin
    int r;
    int saved;
    reset_n  = 1'b0;
    tx_ready = 1'b1;
    req_data = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_cmpl", 32'(cmpl), 0);
    check("rst_send", 32'(tx_send), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_to", 32'(timeout_err), 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Fairness: all four request, requester 0 twice -> order 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_data(i, DW'(9'h100 + 17 * i));
    push_frame(0, 9'h100, 1'b0);
    push_frame(1, 9'h111, 1'b1);
    push_frame(2, 9'h122, 1'b1);
    push_frame(3, 9'h133, 1'b1);
    push_frame(0, 9'h100, 1'b1);
    for (int i = 0; i < 5; i++) delay_q.push_back(10);
    want_cnt[0] += 2;
    want_cnt[1] += 1;
    want_cnt[2] += 1;
    want_cnt[3] += 1;
    wait_drain(400);

    // Single request on requester 2, payload changed after ack, tx_done 50 later.
    delay_q.delete();
    set_data(2, 9'h1A5);
    push_frame(2, 9'h1A5, 1'b0);
    delay_q.push_back(50);
    want_cnt[2] += 1;
    r = cyc;
    step();
    set_data(2, 9'h0AA);
    step();
    step();
    check("busy_mid", 32'(busy), 1);
    wait_drain(200);
    check("req_to_ack", ack_cyc - r, 1);

    // Timeout on requester 0, pointer advances so requester 1 goes next.
    delay_q.delete();
    set_data(0, 9'h055);
    set_data(1, 9'h0C3);
    push_exp(K_ACK, 0, 9'h055, 1'b0);
    push_exp(K_TO, 0, 9'h055, 1'b0);
    push_frame(1, 9'h0C3, 1'b0);
    push_frame(0, 9'h055, 1'b1);
    delay_q.push_back(-1);
    delay_q.push_back(4);
    delay_q.push_back(4);
    want_cnt[0] += 2;
    want_cnt[1] += 1;
    wait_drain(400);

    // tx_done in the terminal-count cycle: completion wins.
    delay_q.delete();
    set_data(1, 9'h1FF);
    push_frame(1, 9'h1FF, 1'b0);
    delay_q.push_back(TO - 1);
    want_cnt[1] += 1;
    wait_drain(300);

    // Transmitter not ready: request waits, then ack the cycle after tx_ready.
    delay_q.delete();
    tx_ready = 1'b0;
    set_data(0, 9'h011);
    push_frame(0, 9'h011, 1'b0);
    delay_q.push_back(5);
    want_cnt[0] += 1;
    repeat (20) step();
    check("notready_busy", 32'(busy), 0);
    check("notready_exp", exp_q.size(), 2);
    tx_ready = 1'b1;
    r = cyc;
    wait_drain(100);
    check("ready_to_ack", ack_cyc - r, 1);

    // Request withdrawn before it was granted: never served.
    delay_q.delete();
    tx_ready = 1'b0;
    saved = ack_cnt[2];
    want_cnt[2] += 1;
    repeat (5) step();
    want_cnt[2] -= 1;
    step();
    tx_ready = 1'b1;
    repeat (10) step();
    check("drop_noack", ack_cnt[2], saved);
    check("drop_busy", 32'(busy), 0);

    // Reset during WAIT_DONE: frame abandoned, late tx_done ignored.
    delay_q.delete();
    set_data(2, 9'h0F0);
    push_exp(K_ACK, 2, 9'h0F0, 1'b0);
    delay_q.push_back(30);
    want_cnt[2] += 1;
    repeat (8) step();
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_data", 32'(tx_data), 0);
    check("mid_rst_send", 32'(tx_send), 0);
    check("mid_rst_ack", 32'(ack), 0);
    check("mid_rst_cmpl", 32'(cmpl), 0);
    check("mid_rst_to", 32'(timeout_err), 0);
    check("mid_rst_q", exp_q.size(), 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (30) step();
    check("late_done_busy", 32'(busy), 0);

    // After reset the pointer is 0: requester 0 beats 3.
    delay_q.delete();
    set_data(0, 9'h101);
    set_data(3, 9'h18C);
    push_frame(0, 9'h101, 1'b0);
    push_frame(3, 9'h18C, 1'b1);
    delay_q.push_back(6);
    delay_q.push_back(6);
    want_cnt[0] += 1;
    want_cnt[3] += 1;
    wait_drain(200);

    check("final_q", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
